// File: rtl/cr_clic_kid_param_if.sv
// Bus-interface and arbiter signals for one CLIC interrupt kid.
// The master side is the CLIC core (bus interface plus arbiter); the slave side is the kid.
interface cr_clic_kid_param_if #(
  parameter int CLICINTCTLBITS = 3
);
  logic                      busif_kid_sel;
  logic                      busif_kid_we;
  logic [3:0]                busif_kid_be;
  logic [31:0]               busif_kid_wdata;
  logic                      arb_kid_ack;
  logic                      kid_arb_int_req;
  logic                      kid_arb_int_hv;
  logic [CLICINTCTLBITS:0]   kid_arb_int_all;
  logic [31:0]               kid_busif_rdata;

  modport master (
    output busif_kid_sel, busif_kid_we, busif_kid_be, busif_kid_wdata, arb_kid_ack,
    input  kid_arb_int_req, kid_arb_int_hv, kid_arb_int_all, kid_busif_rdata
  );

  modport slave (
    input  busif_kid_sel, busif_kid_we, busif_kid_be, busif_kid_wdata, arb_kid_ack,
    output kid_arb_int_req, kid_arb_int_hv, kid_arb_int_all, kid_busif_rdata
  );
endinterface

// File: rtl/cr_clic_kid_param.sv
// CLIC interrupt-source slot: input synchronizer, level/edge/polarity trigger logic,
// and the clicintip/clicintie/clicintattr/clicintctl registers for one interrupt.
module cr_clic_kid_param #(
  parameter int CLICINTCTLBITS = 3,
  parameter int INT_SYNC       = 2
) (
  input  logic                 forever_cpuclk,
  input  logic                 clicrst_b,
  input  logic                 int_src,
  cr_clic_kid_param_if.slave   kid,
  output logic                 kid_ctrl_clicintip_en,
  output logic                 kid_ctrl_clicintie_en,
  output logic                 kid_ctrl_clicintattr_en,
  output logic                 kid_ctrl_clicintctl_en,
  output logic                 kid_ctrl_sample_en
);

  localparam int         ALL_W    = CLICINTCTLBITS + 1;
  // Implemented ctl bits are the MSBs; the remaining low bits are constant and read as 1.
  localparam logic [7:0] CTL_MASK = 8'(8'hFF << (8 - CLICINTCTLBITS));

  logic [INT_SYNC-1:0] sync_q, sync_d;
  logic                prev_q;
  logic                ip_q, ip_next;
  logic                ie_q;
  logic                shv_q;
  logic [1:0]          trig_q;
  logic [7:0]          ctl_q;

  logic [3:0]  wr;
  logic        lvl;
  logic        req;
  logic [7:0]  ctl8, attr8;
  logic [31:0] wdata;

  assign wdata  = kid.busif_kid_wdata;
  assign wr     = {4{kid.busif_kid_sel & kid.busif_kid_we}} & kid.busif_kid_be;
  assign sync_d = INT_SYNC'({sync_q, int_src});
  assign lvl    = sync_q[INT_SYNC-1] ^ trig_q[1];

  // Edge mode: set beats clear, so an ack racing a fresh edge never loses it.
  always_comb begin
    // NOTE: default first so every path assigns ip_next and no latch is inferred.
    ip_next = ip_q;
    if (!trig_q[0]) begin
      ip_next = lvl;
    end else if ((lvl & ~prev_q) | (wr[0] & wdata[0])) begin
      ip_next = 1'b1;
    end else if ((wr[0] & ~wdata[0]) | (kid.arb_kid_ack & shv_q)) begin
      ip_next = 1'b0;
    end
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge forever_cpuclk or negedge clicrst_b) begin
    if (!clicrst_b) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      ip_q   <= 1'b0;
      ie_q   <= 1'b0;
      shv_q  <= 1'b0;
      trig_q <= 2'b00;
      ctl_q  <= 8'h00;
    end else begin
      sync_q <= sync_d;
      prev_q <= lvl;
      ip_q   <= ip_next;
      if (wr[1]) ie_q <= wdata[8];
      if (wr[2]) begin
        shv_q  <= wdata[16];
        trig_q <= wdata[18:17];
      end
      if (wr[3]) ctl_q <= wdata[31:24] & CTL_MASK;
    end
  end

  assign req   = ip_q & ie_q;
  assign ctl8  = ctl_q | ~CTL_MASK;
  assign attr8 = {2'b11, 3'b000, trig_q, shv_q};

  assign kid.kid_arb_int_req = req;
  assign kid.kid_arb_int_hv  = req & shv_q;
  assign kid.kid_arb_int_all = req ? ALL_W'({1'b1, ctl_q} >> (8 - CLICINTCTLBITS)) : '0;
  // Zero when not selected so the bus interface can OR all kids together.
  assign kid.kid_busif_rdata = kid.busif_kid_sel ?
                               {ctl8, attr8, 7'b0, ie_q, 7'b0, ip_q} : 32'h0;

  assign kid_ctrl_clicintip_en   = wr[0] | (ip_next != ip_q);
  assign kid_ctrl_clicintie_en   = wr[1];
  assign kid_ctrl_clicintattr_en = wr[2];
  assign kid_ctrl_clicintctl_en  = wr[3];
  assign kid_ctrl_sample_en      = (sync_d != sync_q) | (lvl != prev_q);

  wire unused_wdata = ^{wdata[23:19], wdata[15:9], wdata[7:1]};

endmodule

// File: tb/tb_cr_clic_kid_param.sv
// Directed self-checking bench for cr_clic_kid_param at CLICINTCTLBITS = 3, 0 and 8.
// All three instances share stimulus; expected values flow through a scoreboard queue.
module tb_cr_clic_kid_param;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        int_src = 1'b0;
  logic        sel = 1'b0, we = 1'b0, ack = 1'b0;
  logic [3:0]  be = 4'h0;
  logic [31:0] wdata = 32'h0;

  logic [4:0]  en3, en0, en8;
  logic [31:0] r3, r0, r8;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_item_t;
  sb_item_t sb[$];

  always #5 clk = ~clk;

  cr_clic_kid_param_if #(.CLICINTCTLBITS(3)) if3 ();
  cr_clic_kid_param_if #(.CLICINTCTLBITS(0)) if0 ();
  cr_clic_kid_param_if #(.CLICINTCTLBITS(8)) if8 ();

  assign if3.busif_kid_sel = sel;  assign if0.busif_kid_sel = sel;  assign if8.busif_kid_sel = sel;
  assign if3.busif_kid_we  = we;   assign if0.busif_kid_we  = we;   assign if8.busif_kid_we  = we;
  assign if3.busif_kid_be  = be;   assign if0.busif_kid_be  = be;   assign if8.busif_kid_be  = be;
  assign if3.busif_kid_wdata = wdata;
  assign if0.busif_kid_wdata = wdata;
  assign if8.busif_kid_wdata = wdata;
  assign if3.arb_kid_ack = ack;    assign if0.arb_kid_ack = ack;    assign if8.arb_kid_ack = ack;

  cr_clic_kid_param #(.CLICINTCTLBITS(3), .INT_SYNC(2)) u_kid3 (
    .forever_cpuclk(clk), .clicrst_b(rst_n), .int_src(int_src), .kid(if3.slave),
    .kid_ctrl_clicintip_en(en3[4]), .kid_ctrl_clicintie_en(en3[3]),
    .kid_ctrl_clicintattr_en(en3[2]), .kid_ctrl_clicintctl_en(en3[1]),
    .kid_ctrl_sample_en(en3[0]));

  cr_clic_kid_param #(.CLICINTCTLBITS(0), .INT_SYNC(2)) u_kid0 (
    .forever_cpuclk(clk), .clicrst_b(rst_n), .int_src(int_src), .kid(if0.slave),
    .kid_ctrl_clicintip_en(en0[4]), .kid_ctrl_clicintie_en(en0[3]),
    .kid_ctrl_clicintattr_en(en0[2]), .kid_ctrl_clicintctl_en(en0[1]),
    .kid_ctrl_sample_en(en0[0]));

  cr_clic_kid_param #(.CLICINTCTLBITS(8), .INT_SYNC(2)) u_kid8 (
    .forever_cpuclk(clk), .clicrst_b(rst_n), .int_src(int_src), .kid(if8.slave),
    .kid_ctrl_clicintip_en(en8[4]), .kid_ctrl_clicintie_en(en8[3]),
    .kid_ctrl_clicintattr_en(en8[2]), .kid_ctrl_clicintctl_en(en8[1]),
    .kid_ctrl_sample_en(en8[0]));

  task automatic sb_push(input string tag, input logic [31:0] exp);
    sb_item_t it;
    it.tag = tag;
    it.exp = exp;
    sb.push_back(it);
  endtask

  task automatic check(input logic [31:0] obs);
    sb_item_t it;
    n_cmp++;
    if (sb.size() == 0) begin
      n_err++;
      $error("FAIL sb_empty: observed 0x%08h, no expected value queued", obs);
      return;
    end
    it = sb.pop_front();
    assert (obs === it.exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", it.tag, obs, it.exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [3:0] b, input logic [31:0] d);
    sel = 1'b1; we = 1'b1; be = b; wdata = d;
    step(1);
    sel = 1'b0; we = 1'b0; be = 4'h0; wdata = 32'h0;
  endtask

  task automatic bus_read();
    sel = 1'b1; we = 1'b0;
    #1;
    r3 = if3.kid_busif_rdata;
    r0 = if0.kid_busif_rdata;
    r8 = if8.kid_busif_rdata;
    sel = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    step(2);
    rst_n = 1'b1;
    step(1);

    // Reset state
    sb_push("rst_en", 32'h0);          check(32'(en3));
    sb_push("rst_req", 32'h0);         check(32'(if3.kid_arb_int_req));
    sb_push("rst_all", 32'h0);         check(32'(if3.kid_arb_int_all));
    sb_push("rst_unsel_rdata", 32'h0); check(if3.kid_busif_rdata);
    bus_read();
    sb_push("rst_rdata_n3", 32'h1FC0_0000); check(r3);
    sb_push("rst_ctl_n0", 32'hFF);          check(32'(r0[31:24]));
    sb_push("rst_ctl_n8", 32'h00);          check(32'(r8[31:24]));

    // Level mode: ie=1, ctl=0xA0
    bus_write(4'b1010, 32'hA000_0100);
    int_src = 1'b1;
    step(1); sb_push("lvl_req_c1", 32'h0); check(32'(if3.kid_arb_int_req));
    step(1); sb_push("lvl_req_c2", 32'h0); check(32'(if3.kid_arb_int_req));
    step(1); sb_push("lvl_req_c3", 32'h1); check(32'(if3.kid_arb_int_req));
    sb_push("lvl_all_n3", 32'hD);   check(32'(if3.kid_arb_int_all));
    sb_push("lvl_all_n0", 32'h1);   check(32'(if0.kid_arb_int_all));
    sb_push("lvl_all_n8", 32'h1A0); check(32'(if8.kid_arb_int_all));
    bus_write(4'b0001, 32'h0);
    bus_read();
    sb_push("lvl_sw_clear_ignored", 32'hBFC0_0101); check(r3);
    int_src = 1'b0;
    step(2); sb_push("lvl_drop_c2", 32'h1); check(32'(if3.kid_arb_int_req));
    step(1); sb_push("lvl_drop_c3", 32'h0); check(32'(if3.kid_arb_int_req));

    // Edge mode, rising
    bus_write(4'b0100, 32'h0002_0000);
    int_src = 1'b1;
    step(1);
    int_src = 1'b0;
    step(5);
    bus_read();
    sb_push("edge_pulse_held", 32'hBFC2_0101); check(r3);
    bus_write(4'b0001, 32'h0);
    bus_read();
    sb_push("edge_sw_clear", 32'hBFC2_0100); check(r3);

    // Edge mode, falling (polarity change makes an edge; clear it afterwards)
    bus_write(4'b0100, 32'h0006_0000);
    step(2);
    bus_write(4'b0001, 32'h0);
    bus_read();
    sb_push("fall_after_clear", 32'hBFC6_0100); check(r3);
    int_src = 1'b1;
    step(5);
    bus_read();
    sb_push("fall_rise_ignored", 32'hBFC6_0100); check(r3);
    int_src = 1'b0;
    step(5);
    bus_read();
    sb_push("fall_edge_sets", 32'hBFC6_0101); check(r3);

    // shv=1: ack clears
    bus_write(4'b0100, 32'h0003_0000);
    sb_push("shv_hv_before_ack", 32'h1); check(32'(if3.kid_arb_int_hv));
    ack = 1'b1; step(1); ack = 1'b0;
    sb_push("shv_hv_after_ack", 32'h0); check(32'(if3.kid_arb_int_hv));
    bus_read();
    sb_push("shv_ack_clears", 32'hBFC3_0100); check(r3);

    // shv=0: ack ignored
    bus_write(4'b0100, 32'h0002_0000);
    bus_write(4'b0001, 32'h1);
    ack = 1'b1; step(1); ack = 1'b0;
    bus_read();
    sb_push("noshv_ack_ignored", 32'hBFC2_0101); check(r3);
    sb_push("noshv_hv", 32'h0); check(32'(if3.kid_arb_int_hv));

    // Same cycle: edge + ack(shv) + sw clear -> ip stays set
    bus_write(4'b0100, 32'h0003_0000);
    bus_write(4'b0001, 32'h0);
    int_src = 1'b1;
    step(2);
    sel = 1'b1; we = 1'b1; be = 4'b0001; wdata = 32'h0; ack = 1'b1;
    step(1);
    sel = 1'b0; we = 1'b0; be = 4'h0; ack = 1'b0;
    bus_read();
    sb_push("race_set_wins_n3", 32'hBFC3_0101); check(r3);
    sb_push("race_set_wins_n0", 32'hFFC3_0101); check(r0);
    sb_push("race_set_wins_n8", 32'hA0C3_0101); check(r8);

    // Full-word write updates all four registers at once
    sel = 1'b1; we = 1'b1; be = 4'hF; wdata = 32'h6003_0100;
    #1;
    sb_push("all_be_enables", 32'h1E); check(32'(en3));
    step(1);
    sel = 1'b0; we = 1'b0; be = 4'h0; wdata = 32'h0;
    bus_read();
    sb_push("all_be_n3", 32'h7FC3_0100); check(r3);
    sb_push("all_be_n0", 32'hFFC3_0100); check(r0);
    sb_push("all_be_n8", 32'h60C3_0100); check(r8);

    // Asynchronous reset while ip=1 and int_src=1
    bus_write(4'b0001, 32'h1);
    rst_n = 1'b0;
    #1;
    sb_push("async_rst_req", 32'h0); check(32'(if3.kid_arb_int_req));
    bus_read();
    sb_push("async_rst_rdata", 32'h1FC0_0000); check(r3);
    step(2);
    rst_n = 1'b1;
    bus_write(4'b0100, 32'h0002_0000);
    step(2);
    bus_read();
    sb_push("post_rst_edge_once", 32'h1FC2_0001); check(r3);
    bus_write(4'b0001, 32'h0);
    step(5);
    bus_read();
    sb_push("post_rst_no_reset", 32'h1FC2_0000); check(r3);

    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL sb_leftover: observed %0d queued, expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
